// File: rtl/sobel_scan_controller.sv
// sobel_scan_controller
// Raster-scan sequencer for a KERNEL x KERNEL Sobel window. It walks the
// window across the image with its own row/column counters and drives the
// read, shift, move, calculation and write units through level requests
// that are held until the matching single-cycle done pulse is accepted.
// A row boundary forces a full window reload; interior steps shift the
// window by one column and fetch one new column (read + move handshake).
// A watchdog moves the scan into a sticky ERROR state when a unit stalls.

module sobel_scan_controller #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int KERNEL     = 3,
  parameter int COORD_W    = 10,
  parameter int WDOG       = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               read_done,
  input  logic               move_done,
  input  logic               shift_done,
  input  logic               calculation_done,
  input  logic               write_done,
  output logic               start_read,
  output logic               start_move,
  output logic               start_shift,
  output logic               start_calculation,
  output logic               start_write,
  output logic [COORD_W-1:0] out_col,
  output logic [COORD_W-1:0] out_row,
  output logic               busy,
  output logic               image_done,
  output logic               err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_WRITE,
    S_ADVANCE,
    S_SHIFT,
    S_FETCH,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int OP_W = $clog2(KERNEL * KERNEL + 1);
  localparam int WD_W = $clog2(WDOG + 1);

  localparam logic [OP_W-1:0]    LOAD_LAST = OP_W'(KERNEL * KERNEL - 1);
  localparam logic [OP_W-1:0]    STEP_LAST = OP_W'(KERNEL - 1);
  localparam logic [WD_W-1:0]    WD_LIMIT  = WD_W'(WDOG - 1);
  localparam logic [COORD_W-1:0] LAST_COL  = COORD_W'(IMG_WIDTH - KERNEL);
  localparam logic [COORD_W-1:0] LAST_ROW  = COORD_W'(IMG_HEIGHT - KERNEL);

  state_t          state;
  logic [OP_W-1:0] op_cnt;
  logic [WD_W-1:0] wdog_cnt;
  logic            rd_lat;
  logic            mv_lat;

  logic wait_state;
  logic done_acc;
  logic have_rd;
  logic have_mv;

  // Identify states that wait on a unit and whether this cycle's pulse is one they consume
  always_comb begin
    wait_state = 1'b0;
    done_acc   = 1'b0;
    case (state)
      S_LOAD:  begin wait_state = 1'b1; done_acc = read_done;             end
      S_CALC:  begin wait_state = 1'b1; done_acc = calculation_done;      end
      S_WRITE: begin wait_state = 1'b1; done_acc = write_done;            end
      S_SHIFT: begin wait_state = 1'b1; done_acc = shift_done;            end
      S_FETCH: begin wait_state = 1'b1; done_acc = read_done | move_done; end
      default: begin wait_state = 1'b0; done_acc = 1'b0;                  end
    endcase
  end

  // A fetch half is satisfied by an earlier latched pulse or one arriving now
  assign have_rd = rd_lat | read_done;
  assign have_mv = mv_lat | move_done;

  // Main sequencer: state, window coordinates, op counter, fetch latches, watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_cnt   <= '0;
      wdog_cnt <= '0;
      rd_lat   <= 1'b0;
      mv_lat   <= 1'b0;
      out_col  <= '0;
      out_row  <= '0;
      err      <= 1'b0;
    end else if (abort) begin
      state    <= S_IDLE;
      op_cnt   <= '0;
      wdog_cnt <= '0;
      rd_lat   <= 1'b0;
      mv_lat   <= 1'b0;
      out_col  <= '0;
      out_row  <= '0;
    end else if (wait_state && !done_acc && wdog_cnt == WD_LIMIT) begin
      state    <= S_ERROR;
      err      <= 1'b1;
      op_cnt   <= '0;
      wdog_cnt <= '0;
      rd_lat   <= 1'b0;
      mv_lat   <= 1'b0;
    end else begin
      // Every exit from a wait state happens on an accepted done, so clearing
      // on done also covers the clear-on-state-change rule.
      if (wait_state && !done_acc) begin
        wdog_cnt <= wdog_cnt + WD_W'(1);
      end else begin
        wdog_cnt <= '0;
      end

      case (state)
        S_IDLE, S_ERROR: begin
          if (start) begin
            err     <= 1'b0;
            out_col <= '0;
            out_row <= '0;
            op_cnt  <= '0;
            rd_lat  <= 1'b0;
            mv_lat  <= 1'b0;
            state   <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (read_done) begin
            if (op_cnt == LOAD_LAST) begin
              op_cnt <= '0;
              state  <= S_CALC;
            end else begin
              op_cnt <= op_cnt + OP_W'(1);
            end
          end
        end

        S_CALC: begin
          if (calculation_done) begin
            state <= S_WRITE;
          end
        end

        S_WRITE: begin
          if (write_done) begin
            state <= S_ADVANCE;
          end
        end

        S_ADVANCE: begin
          if (out_col == LAST_COL && out_row == LAST_ROW) begin
            state <= S_DONE;
          end else if (out_col == LAST_COL) begin
            out_col <= '0;
            out_row <= out_row + COORD_W'(1);
            state   <= S_LOAD;
          end else begin
            out_col <= out_col + COORD_W'(1);
            state   <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (shift_done) begin
            if (op_cnt == STEP_LAST) begin
              op_cnt <= '0;
              state  <= S_FETCH;
            end else begin
              op_cnt <= op_cnt + OP_W'(1);
            end
          end
        end

        S_FETCH: begin
          if (have_rd && have_mv) begin
            rd_lat <= 1'b0;
            mv_lat <= 1'b0;
            if (op_cnt == STEP_LAST) begin
              op_cnt <= '0;
              state  <= S_CALC;
            end else begin
              op_cnt <= op_cnt + OP_W'(1);
            end
          end else begin
            rd_lat <= have_rd;
            mv_lat <= have_mv;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Moore request decode straight from the state register
  assign start_read        = (state == S_LOAD) || (state == S_FETCH);
  assign start_move        = (state == S_FETCH);
  assign start_shift       = (state == S_SHIFT);
  assign start_calculation = (state == S_CALC);
  assign start_write       = (state == S_WRITE);
  assign image_done        = (state == S_DONE);
  assign busy              = (state != S_IDLE) && (state != S_ERROR);

endmodule

// File: tb/tb_sobel_scan_controller.sv
// tb_sobel_scan_controller
// Directed bench for sobel_scan_controller on a 5x4 image with a 3x3 window
// and a 16-cycle watchdog. Inputs change 1 time unit after the rising edge,
// so every check looks at the settled state of the cycle just entered.

module tb_sobel_scan_controller;

  localparam int IMG_WIDTH  = 5;
  localparam int IMG_HEIGHT = 4;
  localparam int KERNEL     = 3;
  localparam int COORD_W    = 10;
  localparam int WDOG       = 16;

  // Done pulse encodings: {read, move, shift, calculation, write}
  localparam logic [4:0] D_NONE  = 5'b00000;
  localparam logic [4:0] D_READ  = 5'b10000;
  localparam logic [4:0] D_MOVE  = 5'b01000;
  localparam logic [4:0] D_SHIFT = 5'b00100;
  localparam logic [4:0] D_CALC  = 5'b00010;
  localparam logic [4:0] D_WRITE = 5'b00001;

  // Request encodings in the same bit order as the done pulses
  localparam logic [4:0] R_NONE  = 5'b00000;
  localparam logic [4:0] R_LOAD  = 5'b10000;
  localparam logic [4:0] R_FETCH = 5'b11000;
  localparam logic [4:0] R_SHIFT = 5'b00100;
  localparam logic [4:0] R_CALC  = 5'b00010;

  logic               clk;
  logic               rst;
  logic               start;
  logic               abort;
  logic               read_done;
  logic               move_done;
  logic               shift_done;
  logic               calculation_done;
  logic               write_done;
  logic               start_read;
  logic               start_move;
  logic               start_shift;
  logic               start_calculation;
  logic               start_write;
  logic [COORD_W-1:0] out_col;
  logic [COORD_W-1:0] out_row;
  logic               busy;
  logic               image_done;
  logic               err;

  logic [4:0] req;
  assign req = {start_read, start_move, start_shift, start_calculation, start_write};

  int n_checks;
  int n_fail;

  int         n_reads;
  int         n_shifts;
  int         n_fetches;
  int         n_writes;
  int         n_image_done;
  int         cyc;
  bit         scan_over;
  logic [4:0] d;
  int         col_log [8];
  int         row_log [8];
  int         exp_col [6];
  int         exp_row [6];

  sobel_scan_controller #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .KERNEL    (KERNEL),
    .COORD_W   (COORD_W),
    .WDOG      (WDOG)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .abort            (abort),
    .read_done        (read_done),
    .move_done        (move_done),
    .shift_done       (shift_done),
    .calculation_done (calculation_done),
    .write_done       (write_done),
    .start_read       (start_read),
    .start_move       (start_move),
    .start_shift      (start_shift),
    .start_calculation(start_calculation),
    .start_write      (start_write),
    .out_col          (out_col),
    .out_row          (out_row),
    .busy             (busy),
    .image_done       (image_done),
    .err              (err)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one cycle and let the new state settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the given done pulses for exactly one cycle
  task automatic applyStimulus(input logic [4:0] dones);
    {read_done, move_done, shift_done, calculation_done, write_done} = dones;
    tick();
    {read_done, move_done, shift_done, calculation_done, write_done} = D_NONE;
  endtask

  // Pulse start for one cycle
  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Compare one observed value against its expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Linear directed test sequence
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    {read_done, move_done, shift_done, calculation_done, write_done} = D_NONE;
    exp_col = '{0, 1, 2, 0, 1, 2};
    exp_row = '{0, 0, 0, 1, 1, 1};

    // Reset state
    tick();
    tick();
    checkOutput("reset_req", 32'(req), 32'(R_NONE));
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_image_done", 32'(image_done), 32'd0);
    checkOutput("reset_col", 32'(out_col), 32'd0);
    checkOutput("reset_row", 32'(out_row), 32'd0);
    rst = 1'b0;
    tick();

    // Start latency: one cycle to LOAD
    pulseStart();
    checkOutput("start_latency_req", 32'(req), 32'(R_LOAD));
    checkOutput("start_latency_busy", 32'(busy), 32'd1);

    // Load the first window and go through to the first interior step
    repeat (KERNEL * KERNEL) applyStimulus(D_READ);
    checkOutput("first_load_to_calc", 32'(req), 32'(R_CALC));
    applyStimulus(D_CALC);
    applyStimulus(D_WRITE);
    checkOutput("advance_no_req", 32'(req), 32'(R_NONE));
    checkOutput("advance_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("step1_shift_req", 32'(req), 32'(R_SHIFT));
    checkOutput("step1_col", 32'(out_col), 32'd1);
    repeat (KERNEL) applyStimulus(D_SHIFT);
    checkOutput("step1_fetch_req", 32'(req), 32'(R_FETCH));

    // Split fetch: move now, read three cycles later is one fetch
    applyStimulus(D_MOVE);
    tick();
    tick();
    checkOutput("split_wait_req", 32'(req), 32'(R_FETCH));
    applyStimulus(D_READ);
    checkOutput("split_one_fetch", 32'(req), 32'(R_FETCH));
    // Both in the same cycle: one fetch
    applyStimulus(D_READ | D_MOVE);
    checkOutput("same_cycle_fetch", 32'(req), 32'(R_FETCH));
    // Two reads without a move count once; the move completes the third fetch
    applyStimulus(D_READ);
    applyStimulus(D_READ);
    checkOutput("double_read_pending", 32'(req), 32'(R_FETCH));
    applyStimulus(D_MOVE);
    checkOutput("third_fetch_to_calc", 32'(req), 32'(R_CALC));

    // start while busy is ignored
    pulseStart();
    checkOutput("busy_start_req", 32'(req), 32'(R_CALC));
    checkOutput("busy_start_col", 32'(out_col), 32'd1);

    // Move to the next step's FETCH, then abort alongside a read_done
    applyStimulus(D_CALC);
    applyStimulus(D_WRITE);
    tick();
    checkOutput("step2_col", 32'(out_col), 32'd2);
    repeat (KERNEL) applyStimulus(D_SHIFT);
    checkOutput("step2_fetch_req", 32'(req), 32'(R_FETCH));
    abort = 1'b1;
    read_done = 1'b1;
    tick();
    abort = 1'b0;
    read_done = 1'b0;
    checkOutput("abort_req", 32'(req), 32'(R_NONE));
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_col", 32'(out_col), 32'd0);
    checkOutput("abort_image_done", 32'(image_done), 32'd0);
    tick();
    checkOutput("abort_no_image_done", 32'(image_done), 32'd0);
    pulseStart();
    checkOutput("rescan_req", 32'(req), 32'(R_LOAD));
    checkOutput("rescan_col", 32'(out_col), 32'd0);
    checkOutput("rescan_row", 32'(out_row), 32'd0);

    // Stray write/shift pulses during LOAD leave the read count alone
    repeat (4) applyStimulus(D_READ);
    applyStimulus(D_WRITE);
    applyStimulus(D_SHIFT);
    checkOutput("stray_state", 32'(req), 32'(R_LOAD));
    repeat (4) applyStimulus(D_READ);
    checkOutput("eight_reads_still_load", 32'(req), 32'(R_LOAD));
    applyStimulus(D_READ);
    checkOutput("ninth_read_to_calc", 32'(req), 32'(R_CALC));

    // Watchdog: 16 CALC cycles without calculation_done
    repeat (WDOG - 1) tick();
    checkOutput("wdog_before_req", 32'(req), 32'(R_CALC));
    checkOutput("wdog_before_err", 32'(err), 32'd0);
    tick();
    checkOutput("wdog_err", 32'(err), 32'd1);
    checkOutput("wdog_busy", 32'(busy), 32'd0);
    checkOutput("wdog_req", 32'(req), 32'(R_NONE));
    applyStimulus(D_CALC);
    checkOutput("error_holds_err", 32'(err), 32'd1);
    pulseStart();
    checkOutput("error_start_err", 32'(err), 32'd0);
    checkOutput("error_start_req", 32'(req), 32'(R_LOAD));

    // Reset in SHIFT at out_col=1
    repeat (KERNEL * KERNEL) applyStimulus(D_READ);
    applyStimulus(D_CALC);
    applyStimulus(D_WRITE);
    tick();
    checkOutput("pre_reset_shift", 32'(req), 32'(R_SHIFT));
    checkOutput("pre_reset_col", 32'(out_col), 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("midscan_reset_req", 32'(req), 32'(R_NONE));
    checkOutput("midscan_reset_busy", 32'(busy), 32'd0);
    checkOutput("midscan_reset_col", 32'(out_col), 32'd0);
    start = 1'b1;
    tick();
    checkOutput("reset_and_start_busy", 32'(busy), 32'd0);
    checkOutput("reset_and_start_req", 32'(req), 32'(R_NONE));
    rst = 1'b0;
    start = 1'b0;
    tick();

    // Full scan with every done answered immediately
    n_reads = 0;
    n_shifts = 0;
    n_fetches = 0;
    n_writes = 0;
    n_image_done = 0;
    cyc = 0;
    scan_over = 1'b0;
    pulseStart();
    while (!scan_over && cyc < 400) begin
      if (image_done) n_image_done++;
      if (!busy) begin
        scan_over = 1'b1;
      end else begin
        d = D_NONE;
        if (start_read && start_move) begin
          d = D_READ | D_MOVE;
          n_fetches++;
        end else if (start_read) begin
          d = D_READ;
          n_reads++;
        end else if (start_shift) begin
          d = D_SHIFT;
          n_shifts++;
        end else if (start_calculation) begin
          d = D_CALC;
        end else if (start_write) begin
          d = D_WRITE;
          if (n_writes < 8) begin
            col_log[n_writes] = int'(out_col);
            row_log[n_writes] = int'(out_row);
          end
          n_writes++;
        end
        applyStimulus(d);
      end
      cyc++;
    end
    checkOutput("scan_terminated", 32'(scan_over), 32'd1);
    checkOutput("scan_writes", 32'(n_writes), 32'd6);
    checkOutput("scan_load_reads", 32'(n_reads), 32'd18);
    checkOutput("scan_shifts", 32'(n_shifts), 32'd12);
    checkOutput("scan_fetches", 32'(n_fetches), 32'd12);
    checkOutput("scan_image_done", 32'(n_image_done), 32'd1);
    checkOutput("scan_busy_after", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("scan_col_%0d", i), 32'(col_log[i]), 32'(exp_col[i]));
      checkOutput($sformatf("scan_row_%0d", i), 32'(row_log[i]), 32'(exp_row[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_scan_controller.md
# sobel_scan_controller

Parametrised successor to the fixed 3x3 Sobel sequencer. It runs the full raster scan of one image through the read, shift, move, calculation and write units. It tracks window position with its own row and column counters instead of relying on an external all_done. Additions over the fixed sequencer:
- configurable kernel size;
- full window reload at each row boundary;
- two-event (read + move) fetch handshake;
- synchronous abort;
- watchdog error state.

## Interface
- IMG_WIDTH, 640: image width in pixels; must be >= KERNEL.
- IMG_HEIGHT, 480: image height in pixels; must be >= KERNEL.
- KERNEL, 3: window edge length (3 or 5).
- COORD_W, 10: width of coordinate outputs; must satisfy 2^COORD_W > max(IMG_WIDTH, IMG_HEIGHT).
- WDOG, 1024: cycles a wait state may persist without its done event before ERROR.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin an image; sampled only in IDLE or ERROR.
- abort  in  1  synchronous cancel; returns to IDLE next cycle.
- read_done, move_done, shift_done, calculation_done, write_done  in  1 each  single-cycle completion pulses from the datapath units.
- start_read, start_move, start_shift, start_calculation, start_write  out  1 each  level requests, held until the matching done is accepted.
- out_col, out_row  out  COORD_W each  top-left coordinate of the current window.
- busy  out  1  high in every state except IDLE and ERROR.
- image_done  out  1  one-cycle pulse on scan completion.
- err  out  1  sticky watchdog flag.

## Operation
- States and Moore outputs:
  - IDLE: all outputs 0.
  - LOAD: start_read.
  - CALC: start_calculation.
  - WRITE: start_write.
  - ADVANCE: no requests.
  - SHIFT: start_shift.
  - FETCH: start_move and start_read.
  - DONE: image_done.
  - ERROR: err.
- Output decode: all request outputs decode from the registered state only.
- IDLE: on start, clear out_col, out_row and the op counter, then go to LOAD.
- LOAD: each read_done increments the op counter. After the KERNEL*KERNEL-th read_done, clear the counter and go to CALC.
- CALC: on calculation_done, go to WRITE.
- WRITE: on write_done, go to ADVANCE.
- ADVANCE (single cycle, no inputs sampled), evaluated in priority order:
  1. out_col == IMG_WIDTH-KERNEL and out_row == IMG_HEIGHT-KERNEL: go to DONE.
  2. out_col == IMG_WIDTH-KERNEL: set out_col to 0, increment out_row, go to LOAD (full reload).
  3. Otherwise: increment out_col and go to SHIFT.
- SHIFT: each shift_done counts. After KERNEL of them, clear the counter and go to FETCH.
- FETCH:
  - read_done and move_done are latched independently; they may arrive in the same or different cycles.
  - One fetch completes when both are latched, or when one is latched and the other arrives this cycle.
  - On completion, clear both latches and increment the counter.
  - After KERNEL fetches, go to CALC.
- DONE: go to IDLE.
- ERROR: hold until start, which clears err and behaves exactly as start in IDLE. Only rst or start clears err.
- Out-of-state pulses: done pulses arriving in a state that does not consume them are ignored, including in IDLE.
- Busy start: start outside IDLE and ERROR is ignored.
- abort: from any state, next state is IDLE. Counters, latches and coordinates clear; err is unchanged. No image_done is produced. Abort has priority over every done pulse in the same cycle.
- Watchdog:
  - A counter increments every cycle spent in LOAD, CALC, WRITE, SHIFT or FETCH without an accepted done.
  - It clears on any accepted done and on every state change.
  - On reaching WDOG-1, go to ERROR. rst and abort take priority over this.
- Arithmetic: all counters are unsigned and never wrap. Coordinates never exceed IMG_WIDTH-KERNEL and IMG_HEIGHT-KERNEL.

## Timing
- Reset: state IDLE, all outputs 0, out_col/out_row 0, err 0, all counters and latches 0. rst has priority over abort and start.
- Start latency: start high in IDLE at edge N gives start_read high in cycle N+1.
- Done acceptance: a done accepted at edge N changes the state at N. The next request level is visible from cycle N+1.
- Back-to-back pulses: one per cycle, each counted.
- Minimum cycles per interior pixel, all dones immediate: CALC 1 + WRITE 1 + ADVANCE 1 + SHIFT KERNEL + FETCH KERNEL.
- Window counts: KERNEL*KERNEL reads per row start; KERNEL shifts and KERNEL fetches per interior step.
- Totals: (IMG_WIDTH-KERNEL+1)*(IMG_HEIGHT-KERNEL+1) CALC/WRITE pairs, then exactly one image_done.
- Degenerate image: IMG_WIDTH == KERNEL and IMG_HEIGHT == KERNEL gives one LOAD, CALC, WRITE, then DONE, with no SHIFT.

## Test plan
- Full scan, IMG_WIDTH=5, IMG_HEIGHT=4, KERNEL=3, immediate dones:
  - exactly 6 write_done accepted, 2 LOAD phases of 9 reads, 4 SHIFT/FETCH steps of 3 ops each;
  - coordinate sequence (0,0) (1,0) (2,0) (0,1) (1,1) (2,1);
  - one image_done; busy low afterwards.
- Split fetch: in FETCH, move_done at cycle t and read_done at t+3 count as one fetch. Both in the same cycle also count as one. read_done twice without move_done counts as one.
- Abort during FETCH with read_done in the same cycle: IDLE next cycle, all outputs 0, coordinates 0, no image_done. A following start rescans from (0,0).
- Watchdog, WDOG=16: withhold calculation_done. ERROR is entered after 16 CALC cycles with err=1 and busy=0. start clears err and reaches LOAD.
- Stray pulses: write_done and shift_done pulsed during LOAD leave the read count and state unaffected. start during CALC is ignored.
- Reset mid-scan: rst during SHIFT at out_col=1 gives IDLE and zeroed outputs next cycle. rst and start together keep IDLE.
